// File: rtl/reg_port_arbiter_if.sv
// rtl/reg_port_arbiter_if.sv - requester-side and register-file-side bus of reg_port_arbiter
interface reg_port_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    RPA_req;
  logic [NUM_REQ-1:0]    RPA_wr;
  logic [NUM_REQ*5-1:0]  RPA_addr1;
  logic [NUM_REQ*5-1:0]  RPA_addr2;
  logic [NUM_REQ*5-1:0]  RPA_addr_wr;
  logic [NUM_REQ*32-1:0] RPA_wdata;
  logic [NUM_REQ-1:0]    RPA_gnt;
  logic [NUM_REQ-1:0]    RPA_done;
  logic [31:0]           RPA_rdata1;
  logic [31:0]           RPA_rdata2;
  logic [4:0]            RF_address1;
  logic [4:0]            RF_address2;
  logic [4:0]            RF_address_wr;
  logic                  RF_write;
  logic [31:0]           RF_data_wr;
  logic [31:0]           RF_data_out1;
  logic [31:0]           RF_data_out2;

  modport master (
    output RPA_req, RPA_wr, RPA_addr1, RPA_addr2, RPA_addr_wr, RPA_wdata,
    input  RPA_gnt, RPA_done, RPA_rdata1, RPA_rdata2,
    input  RF_address1, RF_address2, RF_address_wr, RF_write, RF_data_wr,
    output RF_data_out1, RF_data_out2
  );

  modport slave (
    input  RPA_req, RPA_wr, RPA_addr1, RPA_addr2, RPA_addr_wr, RPA_wdata,
    output RPA_gnt, RPA_done, RPA_rdata1, RPA_rdata2,
    output RF_address1, RF_address2, RF_address_wr, RF_write, RF_data_wr,
    input  RF_data_out1, RF_data_out2
  );
endinterface

// File: rtl/reg_port_arbiter.sv
// rtl/reg_port_arbiter.sv - round-robin arbiter sharing one register-file port among NUM_REQ requesters
// Optional RPA_WR_PRIORITY_EN: pending writes beat every pending read.
module reg_port_arbiter #(
  parameter int NUM_REQ = 2
) (
  input logic              RPA_clk,
  input logic              RPA_rst,
  reg_port_arbiter_if.slave bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]      winner_q, winner_d;
  logic               op_wr_q, op_wr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               rf_write_q, rf_write_d;
  logic [4:0]         addr1_q, addr1_d;
  logic [4:0]         addr2_q, addr2_d;
  logic [4:0]         addr_wr_q, addr_wr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata1_q, rdata1_d;
  logic [31:0]        rdata2_q, rdata2_d;

  logic [NUM_REQ-1:0] eligible;
  logic               found;
  logic [PW-1:0]      pick;

  always_comb begin
    int            idx;
    logic [PW-1:0] idx_p;
    idx      = 0;
    idx_p    = '0;
    eligible = bus.RPA_req;
`ifdef RPA_WR_PRIORITY_EN
    if (|(bus.RPA_req & bus.RPA_wr)) begin
      eligible = bus.RPA_req & bus.RPA_wr;
    end
`endif
    found = 1'b0;
    pick  = '0;
    // First eligible index at or after rr_ptr, wrapping past NUM_REQ-1.
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) begin
        idx -= NUM_REQ;
      end
      idx_p = PW'(idx);
      if (!found && eligible[idx_p]) begin
        found = 1'b1;
        pick  = idx_p;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    winner_d   = winner_q;
    op_wr_d    = op_wr_q;
    gnt_d      = gnt_q;
    done_d     = done_q;
    rf_write_d = rf_write_q;
    addr1_d    = addr1_q;
    addr2_d    = addr2_q;
    addr_wr_d  = addr_wr_q;
    wdata_d    = wdata_q;
    rdata1_d   = rdata1_q;
    rdata2_d   = rdata2_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = ACCESS;
          winner_d   = pick;
          op_wr_d    = bus.RPA_wr[pick];
          gnt_d      = NUM_REQ'(1) << pick;
          rf_write_d = bus.RPA_wr[pick];
          addr1_d    = bus.RPA_addr1[int'(pick)*5 +: 5];
          addr2_d    = bus.RPA_addr2[int'(pick)*5 +: 5];
          addr_wr_d  = bus.RPA_addr_wr[int'(pick)*5 +: 5];
          wdata_d    = bus.RPA_wdata[int'(pick)*32 +: 32];
        end
      end
      ACCESS: begin
        state_d    = RESP;
        rf_write_d = 1'b0;
        done_d     = gnt_q;
      end
      RESP: begin
        state_d  = IDLE;
        done_d   = '0;
        gnt_d    = '0;
        rr_ptr_d = (winner_q == PW'(NUM_REQ-1)) ? '0 : winner_q + 1'b1;
        // Keep the last read result visible after the done pulse.
        if (!op_wr_q) begin
          rdata1_d = bus.RF_data_out1;
          rdata2_d = bus.RF_data_out2;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge RPA_clk or posedge RPA_rst) begin
    if (RPA_rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      winner_q   <= '0;
      op_wr_q    <= 1'b0;
      gnt_q      <= '0;
      done_q     <= '0;
      rf_write_q <= 1'b0;
      addr1_q    <= '0;
      addr2_q    <= '0;
      addr_wr_q  <= '0;
      wdata_q    <= '0;
      rdata1_q   <= '0;
      rdata2_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      winner_q   <= winner_d;
      op_wr_q    <= op_wr_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      rf_write_q <= rf_write_d;
      addr1_q    <= addr1_d;
      addr2_q    <= addr2_d;
      addr_wr_q  <= addr_wr_d;
      wdata_q    <= wdata_d;
      rdata1_q   <= rdata1_d;
      rdata2_q   <= rdata2_d;
    end
  end

  assign bus.RPA_gnt       = gnt_q;
  assign bus.RPA_done      = done_q;
  assign bus.RF_write      = rf_write_q;
  assign bus.RF_address1   = addr1_q;
  assign bus.RF_address2   = addr2_q;
  assign bus.RF_address_wr = addr_wr_q;
  assign bus.RF_data_wr    = wdata_q;
  // Register-file read data is already registered, so RESP passes it straight through.
  assign bus.RPA_rdata1    = (state_q == RESP && !op_wr_q) ? bus.RF_data_out1 : rdata1_q;
  assign bus.RPA_rdata2    = (state_q == RESP && !op_wr_q) ? bus.RF_data_out2 : rdata2_q;
endmodule
